clock_display_scan: RTL and testbench

//  Consumes the BCD hour/minute time from the timer clock and drives a 4-digit

---
 rtl/clock_disp_pkg.sv | 18 +
 rtl/clock_display_scan_if.sv | 11 +
 rtl/bcd_to_seg7.sv | 9 +
 rtl/clock_display_scan.sv | 90 +++++++++
 tb/tb_clock_display_scan.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/clock_disp_pkg.sv
// clock_disp_pkg: segment patterns, slot indices and edit-select encodings
// shared by the clock display scanner.
package clock_disp_pkg;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [1:0] SLOT_MIN_ONES = 2'd0;
    localparam logic [1:0] SLOT_MIN_TENS = 2'd1;
    localparam logic [1:0] SLOT_HR_ONES  = 2'd2;
    localparam logic [1:0] SLOT_HR_TENS  = 2'd3;
    typedef enum logic [1:0] {
        EDIT_NONE  = 2'b00,
        EDIT_HOURS = 2'b01,
        EDIT_MINS  = 2'b10,
        EDIT_ALL   = 2'b11
    } edit_sel_e;
endpackage

// File: rtl/clock_display_scan_if.sv
// clock_display_scan_if: time/edit inputs and 7-segment pin outputs of the scanner.
interface clock_display_scan_if;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [1:0] edit_sel;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    modport master (output hour, minute, edit_sel, input seg, dp, an);
    modport slave  (input hour, minute, edit_sel, output seg, dp, an);
endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD nibble to logical {g,f,e,d,c,b,a} pattern, dash for 10..15.
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    always_comb o_seg = (i_bcd > 4'd9) ? SEG_DASH : SEG_DIGIT[i_bcd];
endmodule

// File: rtl/clock_display_scan.sv
// clock_display_scan: scans a 4-digit multiplexed 7-segment clock display with
// per-frame snapshot, blinking colon, edit flashing and leading-zero blanking.
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV    = 1000,
    parameter int BLINK_TICKS = 256,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    clock_display_scan_if.slave  bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_TICKS) + 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_TICKS - 1);

    logic [PW-1:0] r_pre;
    logic [1:0]    r_idx;
    logic          r_started;
    logic [BW-1:0] r_blink;
    logic          r_phase;
    logic [7:0]    r_hour;
    logic [7:0]    r_minute;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    r_an;

    logic       w_tick;
    logic [1:0] w_idx;
    logic [7:0] w_hour;
    logic [7:0] w_minute;
    logic [3:0] w_digit;
    logic [6:0] w_seg;
    logic       w_blank;
    logic [3:0] w_an;

    // Slot 0 reads the live inputs: that is the edge the frame snapshot is taken.
    always_comb begin
        w_tick   = r_pre == P_LAST;
        w_idx    = r_started ? r_idx + 2'd1 : SLOT_MIN_ONES;
        w_hour   = (w_idx == SLOT_MIN_ONES) ? bus.hour   : r_hour;
        w_minute = (w_idx == SLOT_MIN_ONES) ? bus.minute : r_minute;
        w_digit  = (w_idx == SLOT_MIN_ONES) ? w_minute[3:0] :
                   (w_idx == SLOT_MIN_TENS) ? w_minute[7:4] :
                   (w_idx == SLOT_HR_ONES)  ? w_hour[3:0]   : w_hour[7:4];
        w_blank  = (LZ_BLANK && w_idx == SLOT_HR_TENS && w_hour[7:4] == 4'd0) ||
                   (r_phase && bus.edit_sel[0] && w_idx[1]) ||
                   (r_phase && bus.edit_sel[1] && !w_idx[1]);
        w_an     = w_blank ? 4'd0 : 4'b0001 << w_idx;
    end

    bcd_to_seg7 u_dec (.i_bcd(w_digit), .o_seg(w_seg));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre     <= '0;
            r_idx     <= SLOT_MIN_ONES;
            r_started <= 1'b0;
            r_blink   <= '0;
            r_phase   <= 1'b0;
            r_hour    <= '0;
            r_minute  <= '0;
            r_seg     <= {7{ACTIVE_LOW}};
            r_dp      <= ACTIVE_LOW;
            r_an      <= {4{ACTIVE_LOW}};
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_started <= 1'b1;
                r_idx     <= w_idx;
                r_blink   <= (r_blink == B_LAST) ? '0 : r_blink + 1'b1;
                if (r_blink == B_LAST) r_phase <= !r_phase;
                if (w_idx == SLOT_MIN_ONES) begin
                    r_hour   <= bus.hour;
                    r_minute <= bus.minute;
                end
                r_an  <= w_an ^ {4{ACTIVE_LOW}};
                r_seg <= (w_blank ? 7'd0 : w_seg) ^ {7{ACTIVE_LOW}};
                r_dp  <= (w_idx == SLOT_HR_ONES && !r_phase && !w_blank) ^ ACTIVE_LOW;
            end
        end
    end

    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;
    assign bus.an  = r_an;
endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan: directed checks of scan order, snapshot, blink/edit,
// blanking, dash decode and reset on an active-high and an active-low instance.
module tb_clock_display_scan;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] hour = 8'h12;
    logic [7:0] minute = 8'h34;
    logic [1:0] edit_sel = 2'b00;
    int total = 0;
    int bad = 0;

    clock_display_scan_if ia ();
    clock_display_scan_if ib ();
    assign ia.hour = hour;
    assign ia.minute = minute;
    assign ia.edit_sel = edit_sel;
    assign ib.hour = hour;
    assign ib.minute = minute;
    assign ib.edit_sel = edit_sel;

    // A: test configuration; B: active-low pins, no LZ blanking, 3-tick blink.
    clock_display_scan #(.SCAN_DIV(4), .BLINK_TICKS(2), .ACTIVE_LOW(1'b0), .LZ_BLANK(1'b1))
        u_a (.clk(clk), .reset(reset), .bus(ia));
    clock_display_scan #(.SCAN_DIV(4), .BLINK_TICKS(3), .ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0))
        u_b (.clk(clk), .reset(reset), .bus(ib));

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; hour = 8'h12; minute = 8'h34; edit_sel = 2'b00;
        cyc(2);
        reset = 1'b0;
        total++; if (ia.an !== 4'h0) begin bad++; $display("FAIL rst_a_an got=%h exp=0", ia.an); end
        total++; if (ia.seg !== 7'h00) begin bad++; $display("FAIL rst_a_seg got=%h exp=00", ia.seg); end
        total++; if (ia.dp !== 1'b0) begin bad++; $display("FAIL rst_a_dp got=%b exp=0", ia.dp); end
        total++; if (ib.an !== 4'hF) begin bad++; $display("FAIL rst_b_an got=%h exp=f", ib.an); end
        total++; if (ib.seg !== 7'h7F) begin bad++; $display("FAIL rst_b_seg got=%h exp=7f", ib.seg); end
        total++; if (ib.dp !== 1'b1) begin bad++; $display("FAIL rst_b_dp got=%b exp=1", ib.dp); end
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            total++; if (ia.an !== 4'h0) begin bad++; $display("FAIL rst_idle%0d_an got=%h exp=0", i, ia.an); end
        end
    endtask

    task automatic test_scan;
        cyc(1);
        total++; if (ia.an !== 4'h1) begin bad++; $display("FAIL t1_an got=%h exp=1", ia.an); end
        total++; if (ia.seg !== 7'h66) begin bad++; $display("FAIL t1_seg got=%h exp=66", ia.seg); end
        total++; if (ia.dp !== 1'b0) begin bad++; $display("FAIL t1_dp got=%b exp=0", ia.dp); end
        total++; if (ib.an !== 4'hE) begin bad++; $display("FAIL t1_b_an got=%h exp=e", ib.an); end
        total++; if (ib.seg !== 7'h19) begin bad++; $display("FAIL t1_b_seg got=%h exp=19", ib.seg); end
        total++; if (ib.dp !== 1'b1) begin bad++; $display("FAIL t1_b_dp got=%b exp=1", ib.dp); end
        cyc(4);
        total++; if (ia.an !== 4'h2) begin bad++; $display("FAIL t2_an got=%h exp=2", ia.an); end
        total++; if (ia.seg !== 7'h4F) begin bad++; $display("FAIL t2_seg got=%h exp=4f", ia.seg); end
        cyc(4);
        total++; if (ia.an !== 4'h4) begin bad++; $display("FAIL t3_an got=%h exp=4", ia.an); end
        total++; if (ia.seg !== 7'h5B) begin bad++; $display("FAIL t3_seg got=%h exp=5b", ia.seg); end
        total++; if (ia.dp !== 1'b0) begin bad++; $display("FAIL t3_dp got=%b exp=0", ia.dp); end
        total++; if (ib.an !== 4'hB) begin bad++; $display("FAIL t3_b_an got=%h exp=b", ib.an); end
        total++; if (ib.dp !== 1'b0) begin bad++; $display("FAIL t3_b_dp got=%b exp=0", ib.dp); end
        cyc(4);
        total++; if (ia.an !== 4'h8) begin bad++; $display("FAIL t4_an got=%h exp=8", ia.an); end
        total++; if (ia.seg !== 7'h06) begin bad++; $display("FAIL t4_seg got=%h exp=06", ia.seg); end
        cyc(4);
        total++; if (ia.an !== 4'h1) begin bad++; $display("FAIL t5_an got=%h exp=1", ia.an); end
        total++; if (ia.seg !== 7'h66) begin bad++; $display("FAIL t5_seg got=%h exp=66", ia.seg); end
    endtask

    task automatic test_anti_tear;
        minute = 8'h45;
        cyc(4);
        total++; if (ia.an !== 4'h2) begin bad++; $display("FAIL tear_t6_an got=%h exp=2", ia.an); end
        total++; if (ia.seg !== 7'h4F) begin bad++; $display("FAIL tear_t6_seg got=%h exp=4f", ia.seg); end
        minute = 8'h35;
        cyc(4);
        total++; if (ib.an !== 4'hB) begin bad++; $display("FAIL t7_b_an got=%h exp=b", ib.an); end
        total++; if (ib.dp !== 1'b0) begin bad++; $display("FAIL t7_b_dp got=%b exp=0", ib.dp); end
        cyc(8);
        total++; if (ia.an !== 4'h1) begin bad++; $display("FAIL tear_t9_an got=%h exp=1", ia.an); end
        total++; if (ia.seg !== 7'h6D) begin bad++; $display("FAIL tear_t9_seg got=%h exp=6d", ia.seg); end
        cyc(4);
        total++; if (ia.seg !== 7'h4F) begin bad++; $display("FAIL tear_t10_seg got=%h exp=4f", ia.seg); end
    endtask

    task automatic test_blink;
        edit_sel = 2'b10;
        cyc(4);
        total++; if (ia.an !== 4'h4) begin bad++; $display("FAIL t11_an got=%h exp=4", ia.an); end
        total++; if (ia.dp !== 1'b0) begin bad++; $display("FAIL t11_dp got=%b exp=0", ia.dp); end
        total++; if (ib.dp !== 1'b1) begin bad++; $display("FAIL t11_b_dp got=%b exp=1", ib.dp); end
        cyc(8);
        total++; if (ib.an !== 4'hE) begin bad++; $display("FAIL t13_b_an got=%h exp=e", ib.an); end
        total++; if (ib.seg !== 7'h12) begin bad++; $display("FAIL t13_b_seg got=%h exp=12", ib.seg); end
        cyc(4);
        total++; if (ib.an !== 4'hD) begin bad++; $display("FAIL t14_b_an got=%h exp=d", ib.an); end
        cyc(12);
        total++; if (ia.an !== 4'h1) begin bad++; $display("FAIL t17_an got=%h exp=1", ia.an); end
        total++; if (ib.an !== 4'hF) begin bad++; $display("FAIL t17_b_an got=%h exp=f", ib.an); end
        total++; if (ib.seg !== 7'h7F) begin bad++; $display("FAIL t17_b_seg got=%h exp=7f", ib.seg); end
        total++; if (ib.dp !== 1'b1) begin bad++; $display("FAIL t17_b_dp got=%b exp=1", ib.dp); end
        cyc(4);
        total++; if (ib.an !== 4'hF) begin bad++; $display("FAIL t18_b_an got=%h exp=f", ib.an); end
        edit_sel = 2'b01;
        cyc(4);
        total++; if (ia.an !== 4'h0) begin bad++; $display("FAIL t19_an got=%h exp=0", ia.an); end
        total++; if (ia.seg !== 7'h00) begin bad++; $display("FAIL t19_seg got=%h exp=00", ia.seg); end
        total++; if (ia.dp !== 1'b0) begin bad++; $display("FAIL t19_dp got=%b exp=0", ia.dp); end
        total++; if (ib.an !== 4'hB) begin bad++; $display("FAIL t19_b_an got=%h exp=b", ib.an); end
        total++; if (ib.dp !== 1'b0) begin bad++; $display("FAIL t19_b_dp got=%b exp=0", ib.dp); end
        cyc(4);
        total++; if (ia.an !== 4'h0) begin bad++; $display("FAIL t20_an got=%h exp=0", ia.an); end
        cyc(4);
        total++; if (ia.an !== 4'h1) begin bad++; $display("FAIL t21_an got=%h exp=1", ia.an); end
        edit_sel = 2'b00;
    endtask

    task automatic test_lz;
        hour = 8'h07;
        cyc(24);
        total++; if (ia.an !== 4'h4) begin bad++; $display("FAIL lz_t27_an got=%h exp=4", ia.an); end
        total++; if (ia.seg !== 7'h07) begin bad++; $display("FAIL lz_t27_seg got=%h exp=07", ia.seg); end
        total++; if (ib.seg !== 7'h78) begin bad++; $display("FAIL lz_t27_b_seg got=%h exp=78", ib.seg); end
        cyc(4);
        total++; if (ia.an !== 4'h0) begin bad++; $display("FAIL lz_t28_an got=%h exp=0", ia.an); end
        total++; if (ia.seg !== 7'h00) begin bad++; $display("FAIL lz_t28_seg got=%h exp=00", ia.seg); end
        total++; if (ib.an !== 4'h7) begin bad++; $display("FAIL lz_t28_b_an got=%h exp=7", ib.an); end
        total++; if (ib.seg !== 7'h40) begin bad++; $display("FAIL lz_t28_b_seg got=%h exp=40", ib.seg); end
    endtask

    task automatic test_invalid;
        minute = 8'hA9;
        cyc(4);
        total++; if (ia.an !== 4'h1) begin bad++; $display("FAIL inv_t29_an got=%h exp=1", ia.an); end
        total++; if (ia.seg !== 7'h6F) begin bad++; $display("FAIL inv_t29_seg got=%h exp=6f", ia.seg); end
        cyc(4);
        total++; if (ia.an !== 4'h2) begin bad++; $display("FAIL inv_t30_an got=%h exp=2", ia.an); end
        total++; if (ia.seg !== 7'h40) begin bad++; $display("FAIL inv_t30_seg got=%h exp=40", ia.seg); end
        total++; if (ib.an !== 4'hD) begin bad++; $display("FAIL inv_t30_b_an got=%h exp=d", ib.an); end
        total++; if (ib.seg !== 7'h3F) begin bad++; $display("FAIL inv_t30_b_seg got=%h exp=3f", ib.seg); end
    endtask

    task automatic test_mid_reset;
        cyc(4);
        total++; if (ia.an !== 4'h4) begin bad++; $display("FAIL mr_t31_an got=%h exp=4", ia.an); end
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        total++; if (ia.an !== 4'h0) begin bad++; $display("FAIL mr_a_an got=%h exp=0", ia.an); end
        total++; if (ia.seg !== 7'h00) begin bad++; $display("FAIL mr_a_seg got=%h exp=00", ia.seg); end
        total++; if (ia.dp !== 1'b0) begin bad++; $display("FAIL mr_a_dp got=%b exp=0", ia.dp); end
        total++; if (ib.an !== 4'hF) begin bad++; $display("FAIL mr_b_an got=%h exp=f", ib.an); end
        total++; if (ib.seg !== 7'h7F) begin bad++; $display("FAIL mr_b_seg got=%h exp=7f", ib.seg); end
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            total++; if (ia.an !== 4'h0) begin bad++; $display("FAIL mr_idle%0d_an got=%h exp=0", i, ia.an); end
        end
        cyc(1);
        total++; if (ia.an !== 4'h1) begin bad++; $display("FAIL mr_first_an got=%h exp=1", ia.an); end
        total++; if (ia.seg !== 7'h6F) begin bad++; $display("FAIL mr_first_seg got=%h exp=6f", ia.seg); end
        total++; if (ib.an !== 4'hE) begin bad++; $display("FAIL mr_first_b_an got=%h exp=e", ib.an); end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_anti_tear;
        test_blink;
        test_lz;
        test_invalid;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
